int_ctrl: RTL and testbench

//  Interrupt controller that sits directly upstream of CP0.

---
 rtl/int_ctrl.sv | 113 +++++++++++
 tb/tb_int_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Non-nesting interrupt controller in front of CP0: edge-detects the request lines,
// holds them as pending, and runs the request/ack/ERET handshake with the pipeline.
//
// state   | meaning
// IDLE    | no request outstanding; waits for ie and a pending source
// REQ     | int_req high for the frozen int_id; waits for int_ack or ie drop
// SERVICE | handler running; only eret leaves this state
module int_ctrl #(
    parameter int               WIDTH      = 32,
    parameter int               N_IRQ      = 3,
    parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             ie,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             int_ack,
    input  logic             eret,
    output logic             int_req,
    output logic [WIDTH-1:0] handler_addr,
    output logic [2:0]       int_id,
    output logic             epc_we,
    output logic [WIDTH-1:0] epc_out,
    output logic             ie_zero,
    output logic             ie_one,
    output logic [N_IRQ-1:0] pend,
    output logic             in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] edge_det;
    logic [N_IRQ-1:0] ack_mask;

    function automatic logic [2:0] prio(input logic [N_IRQ-1:0] p);
        prio = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (p[i]) prio = 3'(i);
        end
    endfunction

    always_comb begin
        edge_det = irq_in & ~irq_prev;
        ack_mask = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (int_id == 3'(i)) ack_mask[i] = 1'b1;
        end
    end

    assign handler_addr = VEC_BASE + WIDTH'(int_id) * VEC_STRIDE;

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            irq_prev   <= irq_in;
            pend       <= '0;
            int_id     <= 3'd0;
            epc_out    <= '0;
            epc_we     <= 1'b0;
            ie_zero    <= 1'b0;
            ie_one     <= 1'b0;
            int_req    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            irq_prev <= irq_in;
            epc_we   <= 1'b0;
            ie_zero  <= 1'b0;
            ie_one   <= 1'b0;
            pend     <= pend | edge_det;
            case (state)
                IDLE: begin
                    if (ie && (|pend)) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                        int_id  <= prio(pend);
                    end
                end
                REQ: begin
                    // ack outranks a simultaneous ie drop; a fresh edge on the acked bit survives
                    if (int_ack) begin
                        state      <= SERVICE;
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                        epc_out    <= pc_in;
                        epc_we     <= 1'b1;
                        ie_zero    <= 1'b1;
                        pend       <= (pend & ~ack_mask) | edge_det;
                    end else if (!ie) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                        ie_one     <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_req    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Cycle-by-cycle vector table for int_ctrl with hand-computed expectations,
// followed by a bounded request-latency sequence.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [2:0]  irq_in;
    logic        ie;
    logic [31:0] pc_in;
    logic        int_ack;
    logic        eret;
    logic        int_req;
    logic [31:0] handler_addr;
    logic [2:0]  int_id;
    logic        epc_we;
    logic [31:0] epc_out;
    logic        ie_zero;
    logic        ie_one;
    logic [2:0]  pend;
    logic        in_service;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    int_ctrl dut (
        .clk(clk), .clr(clr), .irq_in(irq_in), .ie(ie), .pc_in(pc_in),
        .int_ack(int_ack), .eret(eret), .int_req(int_req),
        .handler_addr(handler_addr), .int_id(int_id), .epc_we(epc_we),
        .epc_out(epc_out), .ie_zero(ie_zero), .ie_one(ie_one),
        .pend(pend), .in_service(in_service)
    );

    typedef struct {
        logic        clr;
        logic [2:0]  irq;
        logic        ie;
        logic [31:0] pc;
        logic        ack;
        logic        eret;
        logic        req;
        logic [2:0]  id;
        logic        we;
        logic [31:0] epc;
        logic        iz;
        logic        io;
        logic [2:0]  pend;
        logic        svc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic c, input logic [2:0] irq, input logic e,
                               input logic [31:0] pc, input logic a, input logic r,
                               input logic req, input logic [2:0] id, input logic we,
                               input logic [31:0] epc, input logic iz, input logic io,
                               input logic [2:0] p, input logic svc);
        vec_t t;
        t.clr = c; t.irq = irq; t.ie = e; t.pc = pc; t.ack = a; t.eret = r;
        t.req = req; t.id = id; t.we = we; t.epc = epc; t.iz = iz; t.io = io;
        t.pend = p; t.svc = svc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        //                clr irq    ie pc     ack er | req id  we epc    iz io pend   svc
        tbl.push_back(v(1, 3'b001, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h0,   0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b001, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h0,   0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b001, 1, 32'h0,   1, 0,  0, 3'd0, 0, 32'h0,   0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b001, 1, 32'h0,   0, 1,  0, 3'd0, 0, 32'h0,   0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b000, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h0,   0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b001, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h0,   0, 0, 3'b001, 0));
        tbl.push_back(v(0, 3'b001, 1, 32'h0,   0, 0,  1, 3'd0, 0, 32'h0,   0, 0, 3'b001, 0));
        tbl.push_back(v(0, 3'b001, 1, 32'h40,  1, 0,  0, 3'd0, 1, 32'h40,  1, 0, 3'b000, 1));
        tbl.push_back(v(0, 3'b001, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h40,  0, 0, 3'b000, 1));
        tbl.push_back(v(0, 3'b001, 0, 32'h0,   0, 1,  0, 3'd0, 0, 32'h40,  0, 1, 3'b000, 0));
        tbl.push_back(v(0, 3'b000, 0, 32'h0,   0, 0,  0, 3'd0, 0, 32'h40,  0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b011, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h40,  0, 0, 3'b011, 0));
        tbl.push_back(v(0, 3'b011, 1, 32'h0,   0, 0,  1, 3'd0, 0, 32'h40,  0, 0, 3'b011, 0));
        tbl.push_back(v(0, 3'b011, 1, 32'h100, 1, 0,  0, 3'd0, 1, 32'h100, 1, 0, 3'b010, 1));
        tbl.push_back(v(0, 3'b011, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h100, 0, 0, 3'b010, 1));
        tbl.push_back(v(0, 3'b011, 0, 32'h0,   0, 1,  0, 3'd0, 0, 32'h100, 0, 1, 3'b010, 0));
        tbl.push_back(v(0, 3'b011, 0, 32'h0,   0, 0,  0, 3'd0, 0, 32'h100, 0, 0, 3'b010, 0));
        tbl.push_back(v(0, 3'b011, 1, 32'h0,   0, 0,  1, 3'd1, 0, 32'h100, 0, 0, 3'b010, 0));
        tbl.push_back(v(0, 3'b011, 1, 32'h200, 1, 0,  0, 3'd1, 1, 32'h200, 1, 0, 3'b000, 1));
        tbl.push_back(v(0, 3'b011, 1, 32'h0,   0, 0,  0, 3'd1, 0, 32'h200, 0, 0, 3'b000, 1));
        tbl.push_back(v(0, 3'b011, 0, 32'h0,   0, 1,  0, 3'd1, 0, 32'h200, 0, 1, 3'b000, 0));
        tbl.push_back(v(0, 3'b000, 0, 32'h0,   0, 0,  0, 3'd1, 0, 32'h200, 0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b000, 1, 32'h0,   0, 0,  0, 3'd1, 0, 32'h200, 0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b100, 0, 32'h0,   0, 0,  0, 3'd1, 0, 32'h200, 0, 0, 3'b100, 0));
        tbl.push_back(v(0, 3'b100, 0, 32'h0,   0, 0,  0, 3'd1, 0, 32'h200, 0, 0, 3'b100, 0));
        tbl.push_back(v(0, 3'b100, 1, 32'h0,   0, 0,  1, 3'd2, 0, 32'h200, 0, 0, 3'b100, 0));
        tbl.push_back(v(0, 3'b100, 1, 32'h0,   0, 0,  1, 3'd2, 0, 32'h200, 0, 0, 3'b100, 0));
        tbl.push_back(v(0, 3'b100, 0, 32'h0,   0, 0,  0, 3'd2, 0, 32'h200, 0, 0, 3'b100, 0));
        tbl.push_back(v(0, 3'b100, 0, 32'h0,   0, 0,  0, 3'd2, 0, 32'h200, 0, 0, 3'b100, 0));
        tbl.push_back(v(0, 3'b100, 1, 32'h0,   0, 0,  1, 3'd2, 0, 32'h200, 0, 0, 3'b100, 0));
        tbl.push_back(v(0, 3'b100, 0, 32'h300, 1, 0,  0, 3'd2, 1, 32'h300, 1, 0, 3'b000, 1));
        tbl.push_back(v(0, 3'b110, 0, 32'h0,   0, 0,  0, 3'd2, 0, 32'h300, 0, 0, 3'b010, 1));
        tbl.push_back(v(0, 3'b110, 0, 32'h0,   0, 0,  0, 3'd2, 0, 32'h300, 0, 0, 3'b010, 1));
        tbl.push_back(v(0, 3'b110, 0, 32'h0,   0, 1,  0, 3'd2, 0, 32'h300, 0, 1, 3'b010, 0));
        tbl.push_back(v(0, 3'b110, 0, 32'h0,   0, 0,  0, 3'd2, 0, 32'h300, 0, 0, 3'b010, 0));
        tbl.push_back(v(0, 3'b110, 1, 32'h0,   0, 0,  1, 3'd1, 0, 32'h300, 0, 0, 3'b010, 0));
        tbl.push_back(v(0, 3'b110, 1, 32'h44,  1, 0,  0, 3'd1, 1, 32'h44,  1, 0, 3'b000, 1));
        tbl.push_back(v(0, 3'b111, 1, 32'h0,   0, 0,  0, 3'd1, 0, 32'h44,  0, 0, 3'b001, 1));
        tbl.push_back(v(1, 3'b111, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h0,   0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b111, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h0,   0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b110, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h0,   0, 0, 3'b000, 0));
        tbl.push_back(v(0, 3'b111, 1, 32'h0,   0, 0,  0, 3'd0, 0, 32'h0,   0, 0, 3'b001, 0));
        tbl.push_back(v(0, 3'b110, 1, 32'h0,   0, 0,  1, 3'd0, 0, 32'h0,   0, 0, 3'b001, 0));
        tbl.push_back(v(0, 3'b111, 1, 32'h80,  1, 0,  0, 3'd0, 1, 32'h80,  1, 0, 3'b001, 1));
        tbl.push_back(v(0, 3'b111, 1, 32'h0,   0, 1,  0, 3'd0, 0, 32'h80,  0, 1, 3'b001, 0));
        tbl.push_back(v(0, 3'b111, 0, 32'h0,   0, 0,  0, 3'd0, 0, 32'h80,  0, 0, 3'b001, 0));
        tbl.push_back(v(0, 3'b111, 1, 32'h0,   0, 0,  1, 3'd0, 0, 32'h80,  0, 0, 3'b001, 0));
        tbl.push_back(v(0, 3'b111, 1, 32'h0,   0, 1,  1, 3'd0, 0, 32'h80,  0, 0, 3'b001, 0));

        foreach (tbl[k]) begin
            clr = tbl[k].clr; irq_in = tbl[k].irq; ie = tbl[k].ie; pc_in = tbl[k].pc;
            int_ack = tbl[k].ack; eret = tbl[k].eret;
            @(posedge clk);
            #1;
            chk($sformatf("r%0d int_req", k), 32'(int_req), 32'(tbl[k].req));
            chk($sformatf("r%0d int_id", k), 32'(int_id), 32'(tbl[k].id));
            if (tbl[k].req)
                chk($sformatf("r%0d handler_addr", k), handler_addr,
                    32'h800 + 32'(tbl[k].id) * 32'h10);
            chk($sformatf("r%0d epc_we", k), 32'(epc_we), 32'(tbl[k].we));
            chk($sformatf("r%0d epc_out", k), epc_out, tbl[k].epc);
            chk($sformatf("r%0d ie_zero", k), 32'(ie_zero), 32'(tbl[k].iz));
            chk($sformatf("r%0d ie_one", k), 32'(ie_one), 32'(tbl[k].io));
            chk($sformatf("r%0d pend", k), 32'(pend), 32'(tbl[k].pend));
            chk($sformatf("r%0d in_service", k), 32'(in_service), 32'(tbl[k].svc));
            chk($sformatf("r%0d strobe_excl", k), 32'(ie_zero & ie_one), 32'd0);
        end

        // Bounded latency check: rising edge on irq 2 to visible int_req
        clr = 1'b1; irq_in = 3'b000; ie = 1'b1; int_ack = 1'b0; eret = 1'b0; pc_in = '0;
        @(posedge clk);
        #1;
        clr = 1'b0; irq_in = 3'b100;
        begin
            int lat;
            lat = 0;
            for (int c = 1; c <= 6; c++) begin
                @(posedge clk);
                #1;
                if (int_req) begin
                    lat = c;
                    break;
                end
            end
            chk("latency_cycles", 32'(lat), 32'd2);
            chk("latency_addr", handler_addr, 32'h820);
            chk("latency_id", 32'(int_id), 32'd2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
